// File: rtl/game_pkg.sv
// Shared game definitions: board geometry, tile exponents, spawn FSM states.
package game_pkg;

    localparam int unsigned CELLS   = 16;
    localparam int unsigned EXP_W   = 4;
    localparam int unsigned BOARD_W = CELLS * EXP_W;

    localparam logic [EXP_W-1:0] EXP_EMPTY = 4'd0;
    localparam logic [EXP_W-1:0] EXP_TWO   = 4'd1;
    localparam logic [EXP_W-1:0] EXP_FOUR  = 4'd2;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } spawn_state_t;

    // Extract the exponent of cell idx (cell i lives at [4i+3:4i]).
    function automatic logic [EXP_W-1:0] cell_get(input logic [BOARD_W-1:0] board,
                                                 input logic [3:0]         idx);
        return board[idx*EXP_W +: EXP_W];
    endfunction

endpackage

// File: rtl/tile_spawner_if.sv
// Spawn request/response bundle between the move pipeline and tile_spawner.
interface tile_spawner_if;
    import game_pkg::*;

    logic               spawn_req;
    logic [7:0]         rnd;
    logic [BOARD_W-1:0] board_in;
    logic [BOARD_W-1:0] board_out;
    logic [3:0]         spawn_idx;
    logic               busy;
    logic               done;
    logic               full;

    modport master (
        output spawn_req, rnd, board_in,
        input  board_out, spawn_idx, busy, done, full
    );

    modport slave (
        input  spawn_req, rnd, board_in,
        output board_out, spawn_idx, busy, done, full
    );

endinterface

// File: rtl/tile_spawner.sv
// Places one new tile ("2" or "4") in the first empty cell found by a circular
// scan starting at a random index; flags a full board after 16 probes.
module tile_spawner
    import game_pkg::*;
#(
    parameter int unsigned CELLS = 16,
    parameter int unsigned EXP_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    tile_spawner_if.slave  bus
);

    localparam int unsigned BW = CELLS * EXP_W;

    spawn_state_t      state_q, state_d;
    logic [BW-1:0]     brd_q;
    logic [BW-1:0]     brd_wr;
    logic [3:0]        idx_q;
    logic [3:0]        cnt_q;
    logic [EXP_W-1:0]  exp_q;
    logic [BW-1:0]     board_out_q;
    logic [3:0]        spawn_idx_q;
    logic              full_q;

    logic              hit;
    logic              last;

    assign hit  = (cell_get(brd_q, idx_q) == EXP_EMPTY);
    assign last = (cnt_q == 4'd15);

    // Next-state logic for the IDLE -> SCAN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.spawn_req) state_d = SCAN;
            SCAN:    if (hit || last)   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched board with the new tile written into the probed cell.
    always_comb begin
        brd_wr = brd_q;
        for (int i = 0; i < int'(CELLS); i++) begin
            if (4'(i) == idx_q) brd_wr[i*EXP_W +: EXP_W] = exp_q;
        end
    end

    // State register and scan datapath; results register on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            brd_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            board_out_q <= '0;
            spawn_idx_q <= '0;
            full_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (bus.spawn_req) begin
                        brd_q <= bus.board_in;
                        idx_q <= bus.rnd[3:0];
                        cnt_q <= '0;
                        // 1-in-8 chance of a "4"
                        exp_q <= (bus.rnd[7:5] == 3'b000) ? EXP_FOUR : EXP_TWO;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        brd_q       <= brd_wr;
                        board_out_q <= brd_wr;
                        spawn_idx_q <= idx_q;
                        full_q      <= 1'b0;
                    end else if (last) begin
                        board_out_q <= brd_q;
                        full_q      <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

    assign bus.board_out = board_out_q;
    assign bus.spawn_idx = spawn_idx_q;
    assign bus.full      = full_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_tile_spawner.sv
// Bench for tile_spawner: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_tile_spawner;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tile_spawner_if sif();

    tile_spawner dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-transaction result: first empty cell in circular order from rnd[3:0].
    function automatic void spawn_model(input logic [63:0] b, input logic [7:0] r,
                                        output int k, output logic [63:0] nb,
                                        output logic [3:0] pos, output bit fl);
        int i;
        fl  = 1'b1;
        nb  = b;
        k   = 15;
        pos = 4'd0;
        for (int c = 0; c < 16; c++) begin
            i = (int'(r[3:0]) + c) % 16;
            if (b[i*4 +: 4] == 4'd0) begin
                nb[i*4 +: 4] = (r[7:5] == 3'b000) ? 4'd2 : 4'd1;
                pos = 4'(i);
                k   = c;
                fl  = 1'b0;
                break;
            end
        end
    endfunction

    // Model: a request starts a countdown of (probes+1) edges, then one done cycle.
    bit          m_active = 0, m_done = 0, m_full = 0;
    int          m_timer  = 0;
    logic [63:0] m_board_out = '0;
    logic [3:0]  m_idx = '0;
    bit          p_full;
    logic [63:0] p_board;
    logic [3:0]  p_idx;

    always @(posedge clk) begin
        int k;
        if (rst) begin
            m_active = 0; m_done = 0; m_full = 0; m_timer = 0;
            m_board_out = '0; m_idx = '0;
        end else if (m_done) begin
            m_done = 0;
            m_active = 0;
        end else if (m_active) begin
            m_timer--;
            if (m_timer == 0) begin
                m_done      = 1;
                m_board_out = p_board;
                m_full      = p_full;
                if (!p_full) m_idx = p_idx;
            end
        end else if (sif.spawn_req) begin
            spawn_model(sif.board_in, sif.rnd, k, p_board, p_idx, p_full);
            m_active = 1;
            m_timer  = k + 1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(sif.busy), 64'(m_active));
            check("done", 64'(sif.done), 64'(m_done));
            check("full", 64'(sif.full), 64'(m_full));
            check("board_out", sif.board_out, m_board_out);
            if (m_done && !m_full) check("spawn_idx", 64'(sif.spawn_idx), 64'(m_idx));
        end
    end

    task automatic req(input logic [63:0] b, input logic [7:0] r);
        @(negedge clk);
        sif.board_in  = b;
        sif.rnd       = r;
        sif.spawn_req = 1'b1;
        @(negedge clk);
        sif.spawn_req = 1'b0;
    endtask

    // Called at cycle 1 after the request; returns the cycle done was seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!sif.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!sif.done) begin
            errors++;
            checks++;
            $display("FAIL wait_done: no done pulse within 40 cycles");
        end
    endtask

    task automatic directed(input string name, input logic [63:0] b, input logic [7:0] r,
                            input int lat, input logic [63:0] exp_b,
                            input logic [3:0] exp_i, input bit exp_f);
        int cyc;
        req(b, r);
        wait_done(cyc);
        check({name, " latency"}, 64'(cyc), 64'(lat));
        check({name, " board_out"}, sif.board_out, exp_b);
        check({name, " full"}, 64'(sif.full), 64'(exp_f));
        if (!exp_f) check({name, " spawn_idx"}, 64'(sif.spawn_idx), 64'(exp_i));
        @(negedge clk);
    endtask

    function automatic logic [63:0] gen_board();
        logic [63:0] b;
        int dens;
        dens = $urandom_range(16);
        for (int c = 0; c < 16; c++)
            b[c*4 +: 4] = ($urandom_range(15) < dens) ? 4'($urandom_range(11, 1)) : 4'd0;
        return b;
    endfunction

    initial begin
        int cnt;
        rst = 1'b1;
        sif.spawn_req = 1'b0;
        sif.rnd = '0;
        sif.board_in = '0;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", 64'(sif.busy), 64'd0);
        check("reset board_out", sif.board_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        directed("empty", 64'h0, 8'h25, 2, 64'h0000_0000_0010_0000, 4'd5, 1'b0);
        directed("wrap", 64'h3333_0000_0000_0000, 8'h1C, 6, 64'h3333_0000_0000_0002, 4'd0, 1'b0);
        directed("full", 64'h1111_1111_1111_1111, 8'h47, 17, 64'h1111_1111_1111_1111, 4'd0,
                 1'b1);
        directed("last", 64'h1111_1101_1111_1111, 8'hAA, 17, 64'h1111_1111_1111_1111, 4'd9,
                 1'b0);

        // Requests during a scan are dropped.
        req(64'h1111_1111_1111_1111, 8'h03);
        @(negedge clk); sif.spawn_req = 1'b1;
        @(negedge clk); sif.spawn_req = 1'b0;
        @(negedge clk); sif.spawn_req = 1'b1;
        @(negedge clk); sif.spawn_req = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (sif.done) cnt++;
        end
        check("ignored req done count", 64'(cnt), 64'd1);
        check("ignored req idle", 64'(sif.busy), 64'd0);

        // Reset mid-scan.
        req(64'h1111_1111_1111_1111, 8'h00);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midscan rst busy", 64'(sif.busy), 64'd0);
        check("midscan rst done", 64'(sif.done), 64'd0);
        check("midscan rst board_out", sif.board_out, 64'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (sif.done) cnt++;
        end
        check("midscan rst no done", 64'(cnt), 64'd0);

        // Randomized traffic, including board_in churn and requests while busy.
        repeat (3000) begin
            @(negedge clk);
            sif.spawn_req = ($urandom_range(3) == 0);
            sif.rnd       = 8'($urandom);
            sif.board_in  = gen_board();
            rst           = ($urandom_range(199) == 0);
        end
        @(negedge clk);
        sif.spawn_req = 1'b0;
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
